// File: rtl/lcd_hex_feeder.sv
// Converts a 32-bit value to 8 ASCII hex characters and writes them to the DE2 character-LCD controller as two words.
// Define LCD_HEX_LOWERCASE_EN to emit a-f instead of A-F.
module lcd_hex_feeder #(
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        lcd_available,
  output logic [31:0] lcd_data,
  output logic        lcd_selectCD,
  output logic        lcd_enableWriting,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_HI,
    ACK_HI,
    SEND_LO,
    ACK_LO,
    FIN
  } StateT;

  StateT           state;
  StateT           nextState;
  logic [15:0]     dataLo;
  logic [TO_W-1:0] ackCnt;
  logic            ackExpired;

  function automatic logic [7:0] hexChar(input logic [3:0] n);
    if (n <= 4'd9) begin
      return 8'h30 + {4'h0, n};
    end
`ifdef LCD_HEX_LOWERCASE_EN
    return 8'h57 + {4'h0, n};
`else
    return 8'h37 + {4'h0, n};
`endif
  endfunction

  function automatic logic [31:0] toAscii(input logic [15:0] v);
    return {hexChar(v[15:12]), hexChar(v[11:8]), hexChar(v[7:4]), hexChar(v[3:0])};
  endfunction

  assign ackExpired = (ackCnt == TO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // An acknowledge (available low) takes priority over a timeout expiring in the same cycle.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (in_valid) nextState = SEND_HI;
      SEND_HI: if (lcd_available) nextState = ACK_HI;
      ACK_HI: begin
        if (!lcd_available) nextState = SEND_LO;
        else if (ackExpired) nextState = IDLE;
      end
      SEND_LO: if (lcd_available) nextState = ACK_LO;
      ACK_LO: begin
        if (!lcd_available) nextState = FIN;
        else if (ackExpired) nextState = IDLE;
      end
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // lcd_data only changes on accept or on the HI acknowledge, so it is stable while the controller latches it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcd_data    <= '0;
      dataLo      <= '0;
      timeout_err <= 1'b0;
      ackCnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dataLo      <= in_data[15:0];
            lcd_data    <= toAscii(in_data[31:16]);
            timeout_err <= 1'b0;
          end
        end
        SEND_HI, SEND_LO: begin
          ackCnt <= '0;
        end
        ACK_HI: begin
          if (!lcd_available) lcd_data <= toAscii(dataLo);
          else if (ackExpired) timeout_err <= 1'b1;
          else ackCnt <= ackCnt + 1'b1;
        end
        ACK_LO: begin
          if (lcd_available) begin
            if (ackExpired) timeout_err <= 1'b1;
            else ackCnt <= ackCnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    in_ready          = (state == IDLE);
    busy              = (state != IDLE);
    done              = (state == FIN);
    lcd_selectCD      = 1'b1;
    lcd_enableWriting = ((state == SEND_HI) || (state == SEND_LO)) && lcd_available;
  end

endmodule

// File: tb/tb_lcd_hex_feeder.sv
// Scoreboard bench for lcd_hex_feeder with a behavioural model of the LCD controller's available handshake.
// Expected words follow LCD_HEX_LOWERCASE_EN when it is defined.
module tb_lcd_hex_feeder;

  localparam int ACK_TIMEOUT = 255;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        lcd_available;
  logic [31:0] lcd_data;
  logic        lcd_selectCD;
  logic        lcd_enableWriting;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;
  int pulseCount = 0;
  int doneCount = 0;

  logic [31:0] expWords[$];
  int          expDone[$];

  bit lcdOffline = 0;
  bit noAck = 0;
  int ackLow = 3;

  lcd_hex_feeder #(.ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .lcd_available(lcd_available),
    .lcd_data(lcd_data),
    .lcd_selectCD(lcd_selectCD),
    .lcd_enableWriting(lcd_enableWriting),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flagFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s", name);
  endtask

  function automatic logic [31:0] pick(input logic [31:0] upper, input logic [31:0] lower);
`ifdef LCD_HEX_LOWERCASE_EN
    return lower;
`else
    return upper;
`endif
  endfunction

  // LCD controller model: available stays high one cycle after a request, then drops for ackLow cycles.
  initial begin
    bit req;
    bit pendLow;
    int lowLeft;
    pendLow = 0;
    lowLeft = 0;
    lcd_available = 1;
    forever begin
      @(negedge clk);
      req = lcd_enableWriting;
      @(posedge clk);
      #1;
      if (lcdOffline) begin
        lcd_available = 0;
        pendLow = 0;
        lowLeft = 0;
      end else if (noAck) begin
        lcd_available = 1;
      end else if (req) begin
        pendLow = 1;
        lcd_available = 1;
      end else if (pendLow) begin
        pendLow = 0;
        lcd_available = 0;
        lowLeft = ackLow;
      end else if (lowLeft > 0) begin
        lowLeft--;
        if (lowLeft == 0) lcd_available = 1;
      end else begin
        lcd_available = 1;
      end
    end
  end

  // Monitor: every write request and done pulse is matched against the scoreboard queues.
  initial begin
    logic [31:0] w;
    bit prevEn;
    prevEn = 0;
    forever begin
      @(negedge clk);
      if (rst && lcd_enableWriting) begin
        pulseCount++;
        checkOutput("enableGap", {31'b0, prevEn}, 32'd0);
        if (expWords.size() == 0) begin
          flagFail("unexpectedWrite");
        end else begin
          w = expWords.pop_front();
          checkOutput("lcdData", lcd_data, w);
          checkOutput("selectCD", {31'b0, lcd_selectCD}, 32'd1);
        end
      end
      prevEn = lcd_enableWriting;
      if (rst && done) begin
        doneCount++;
        if (expDone.size() == 0) flagFail("unexpectedDone");
        else void'(expDone.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] value);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) flagFail("readyTimeout");
    @(posedge clk);
    #1;
    in_data = value;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  task automatic waitDone(input int target);
    int n;
    n = 0;
    while (doneCount < target && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (doneCount < target) flagFail("doneTimeout");
  endtask

  task automatic waitPulses(input int target);
    int n;
    n = 0;
    while (pulseCount < target && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (pulseCount < target) flagFail("pulseTimeout");
  endtask

  task automatic expectTransfer(input logic [31:0] hi, input logic [31:0] lo, input bit withDone);
    expWords.push_back(hi);
    expWords.push_back(lo);
    if (withDone) expDone.push_back(1);
  endtask

  initial begin
    int base;
    int cnt;
    rst = 1;
    in_data = 0;
    in_valid = 0;
    #3 rst = 0;
    #1;
    checkOutput("rstReady", {31'b0, in_ready}, 32'd1);
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    checkOutput("rstData", lcd_data, 32'd0);
    checkOutput("rstEnable", {31'b0, lcd_enableWriting}, 32'd0);
    checkOutput("rstDone", {31'b0, done}, 32'd0);
    checkOutput("rstTimeout", {31'b0, timeout_err}, 32'd0);
    checkOutput("rstSelectCD", {31'b0, lcd_selectCD}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1;

    $display("[TB] DEADBEEF, ack low 3 cycles");
    ackLow = 3;
    expectTransfer(pick(32'h44454144, 32'h64656164), pick(32'h42454546, 32'h62656566), 1);
    applyStimulus(32'hDEADBEEF);
    waitDone(1);

    $display("[TB] 0123ABCD, ack low 1 cycle");
    ackLow = 1;
    expectTransfer(32'h30313233, pick(32'h41424344, 32'h61626364), 1);
    applyStimulus(32'h0123ABCD);
    waitDone(2);

    $display("[TB] LCD unavailable for 100 cycles");
    ackLow = 2;
    lcdOffline = 1;
    @(posedge clk);
    base = pulseCount;
    expectTransfer(pick(32'h46464646, 32'h66666666), 32'h30303030, 1);
    applyStimulus(32'hFFFF0000);
    repeat (100) @(negedge clk);
    #1;
    checkOutput("offlinePulses", pulseCount, base);
    checkOutput("offlineBusy", {31'b0, busy}, 32'd1);
    checkOutput("offlineReady", {31'b0, in_ready}, 32'd0);
    lcdOffline = 0;
    waitDone(3);

    $display("[TB] input while busy is ignored");
    base = pulseCount;
    expectTransfer(pick(32'h38394142, 32'h38396162), pick(32'h43444546, 32'h63646566), 1);
    applyStimulus(32'h89ABCDEF);
    in_data = 32'h11111111;
    in_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 0;
    waitDone(4);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("ignorePulses", pulseCount, base + 2);
    checkOutput("ignoreReady", {31'b0, in_ready}, 32'd1);

    $display("[TB] acknowledge timeout");
    noAck = 1;
    @(posedge clk);
    base = pulseCount;
    expWords.push_back(32'h30303030);
    applyStimulus(32'h00000000);
    waitPulses(base + 1);
    cnt = 0;
    while (!timeout_err && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("timeoutCycles", cnt, ACK_TIMEOUT + 1);
    checkOutput("timeoutErr", {31'b0, timeout_err}, 32'd1);
    checkOutput("timeoutReady", {31'b0, in_ready}, 32'd1);
    checkOutput("timeoutPulses", pulseCount, base + 1);
    checkOutput("timeoutNoDone", doneCount, 4);
    noAck = 0;
    repeat (2) @(posedge clk);

    $display("[TB] next input clears timeout_err");
    ackLow = 2;
    expectTransfer(pick(32'h35413541, 32'h35613561), pick(32'h35413541, 32'h35613561), 1);
    applyStimulus(32'h5A5A5A5A);
    checkOutput("timeoutCleared", {31'b0, timeout_err}, 32'd0);
    waitDone(5);

    $display("[TB] reset during ACK_LO");
    base = pulseCount;
    expectTransfer(pick(32'h43414645, 32'h63616665), 32'h31323334, 0);
    applyStimulus(32'hCAFE1234);
    waitPulses(base + 2);
    @(posedge clk);
    #2 rst = 0;
    #1;
    checkOutput("midRstReady", {31'b0, in_ready}, 32'd1);
    checkOutput("midRstBusy", {31'b0, busy}, 32'd0);
    checkOutput("midRstData", lcd_data, 32'd0);
    checkOutput("midRstEnable", {31'b0, lcd_enableWriting}, 32'd0);
    checkOutput("midRstSelectCD", {31'b0, lcd_selectCD}, 32'd1);
    @(negedge clk);
    rst = 1;
    repeat (6) @(negedge clk);
    #1;
    checkOutput("postRstReady", {31'b0, in_ready}, 32'd1);
    checkOutput("postRstQueue", expWords.size(), 0);
    checkOutput("postRstNoDone", doneCount, 5);

    $display("[TB] transfer after reset");
    expectTransfer(pick(32'h30304330, 32'h30306330), pick(32'h46464545, 32'h66666565), 1);
    applyStimulus(32'h00C0FFEE);
    waitDone(6);
    repeat (5) @(negedge clk);
    #1;
    checkOutput("finalQueue", expWords.size(), 0);
    checkOutput("finalDoneQueue", expDone.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
